pipe_regfile_sb: RTL and testbench
==================================

Name: pipe_regfile_sb

Overview:
- Parametrised register file with a load scoreboard for the RISC-V pipeline.
- Replaces the fixed 2-read/31-entry register array embedded in the pipeline top.
- Adds N read ports, write-back bypass, and an in-order queue of outstanding load destinations, so loads with variable memory latency stall only their true dependents.
- Sits between decode (read ports), execute/WB (ALU write) and the data-memory return path (load write).

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers, power of 2; x0 is hardwired to zero
NRD, 2, number of read ports
LD_DEPTH, 4, maximum outstanding loads (destination FIFO depth), power of 2
RW = $clog2(NREG), register index width (localparam)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
rd_sel  in  NRD*RW  packed read indices, port i at [i*RW +: RW]
rd_data  out  NRD*XLEN  packed read data, combinational
wb_we  in  1  ALU/JAL/LUI write enable
wb_sel  in  RW  ALU write destination
wb_data  in  XLEN  ALU write data
ld_issue  in  1  load issued; push ld_sel to the pending FIFO
ld_sel  in  RW  load destination
ld_valid  in  1  load data returning (in issue order)
ld_data  in  XLEN  returned load data
hazard_stall  out  1  some read port selects a pending register
ld_full  out  1  FIFO holds LD_DEPTH entries
ld_count  out  $clog2(LD_DEPTH+1)  FIFO occupancy
ld_err  out  2  sticky error flags: [0] overflow, [1] underflow

Behaviour:
- Reset (async, immediate): all registers = 0, FIFO empty, per-register pending counters = 0, ld_err = 0. Reset mid-operation discards all outstanding loads.
- Storage: registers 1..NREG-1 as flops. Index 0 always reads 0, is never written, and is never pending.
- Writes take effect on the rising edge. Sources:
  - ALU write: wb_we with wb_sel != 0.
  - Load write: ld_valid with FIFO non-empty writes ld_data to the FIFO head's register.
  - Both to the same register in the same cycle: wb_data is written (younger instruction wins).
- Pending counters: each register has a counter, width $clog2(LD_DEPTH+1).
  - Incremented on an accepted ld_issue with ld_sel != 0.
  - Decremented on a load pop targeting that register.
  - Issue and pop to the same register in the same cycle: counter unchanged.
  - A register is pending while its counter is nonzero.
- FIFO: circular, head/tail pointers with wrap-around; ld_count reflects occupancy.
  - Push on ld_issue and (!ld_full or ld_valid), so issue and return in the same cycle while full is legal.
  - ld_issue with ld_sel = 0 still pushes, keeping return order aligned. Its pop writes nothing and touches no counter.
- Errors:
  - ld_issue while full without ld_valid: push dropped, ld_err[0] set.
  - ld_valid while empty: ignored, ld_err[1] set.
  - Flags clear only on reset.
- Read path, per port, in priority order (combinational, zero latency):
  1. Index 0 → 0.
  2. Match on an active ALU write → wb_data.
  3. Match on an active load pop → ld_data.
  4. Otherwise → stored value.
- hazard_stall = OR over ports of (rd_sel != 0 and counter[rd_sel] != 0 and the port is not satisfied by this cycle's bypass). If the counter is exactly 1 and that load is popping now, there is no stall.
- Counters never wrap, because pushes are bounded by LD_DEPTH.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: read path and hazard_stall behave as in Behaviour, including the same-cycle bypass.
- Undefined:
  - rd_data returns stored values only.
  - hazard_stall additionally asserts when any nonzero rd_sel equals wb_sel with wb_we, or equals the popping load's register with ld_valid.
  - Saves the bypass muxes at the cost of one bubble per back-to-back dependency.

Test Plan:
- Reset, then read x0..x31 on both ports → all 0. wb_we with wb_sel=0, wb_data=0xDEAD, then read x0 → 0.
- Bypass: wb_we with wb_sel=5, wb_data=0x1234 while rd_sel[0]=5 in the same cycle → rd_data[0]=0x1234 (with REGFILE_BYPASS_EN), no stall. After the edge, stored x5=0x1234.
- Load-use: ld_issue with ld_sel=7 → reading x7 gives hazard_stall=1. Three cycles later, ld_valid with ld_data=0xCAFE → same cycle stall=0, rd_data=0xCAFE. After the edge, x7=0xCAFE and its counter is 0.
- Ordering/full: issue loads to x3, x3, x4, x9 → ld_full=1, ld_count=4, x3 counter=2.
  - 5th issue without return → ld_err[0]=1, ld_count stays 4.
  - 5th issue together with ld_valid → accepted, count stays 4.
  - Returns go in order: x3, x3, x4, x9.
- WAW collision: pending load to x2 pops while wb_we writes x2=0x55 with ld_data=0x99 → x2=0x55. ld_valid when empty → ld_err[1]=1, no register changes.
- Async reset asserted with 2 loads outstanding → ld_count=0 and hazard_stall=0 immediately, without a clock edge.

Source files
------------

// File: rtl/pipe_regfile_sb.sv
// pipe_regfile_sb: parametrised register file with an in-order load scoreboard for the RISC-V pipeline.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-back/load-return bypass on the read ports.
module pipe_regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int LD_DEPTH = 4,
    localparam int RW      = $clog2(NREG),
    localparam int CW      = $clog2(LD_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*RW-1:0]   rd_sel,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wb_we,
    input  logic [RW-1:0]       wb_sel,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                ld_issue,
    input  logic [RW-1:0]       ld_sel,
    input  logic                ld_valid,
    input  logic [XLEN-1:0]     ld_data,
    output logic                hazard_stall,
    output logic                ld_full,
    output logic [CW-1:0]       ld_count,
    output logic [1:0]          ld_err
);

    localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;

    logic [XLEN-1:0] regs [NREG];
    logic [CW-1:0]   pend [NREG];
    logic [RW-1:0]   fifo [LD_DEPTH];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count;

    logic            push, pop, pop_wr, wb_act, overflow, underflow;
    logic [RW-1:0]   pop_sel;
    logic [NRD-1:0]  port_stall;

    assign ld_full   = (count == CW'(LD_DEPTH));
    assign ld_count  = count;
    assign pop       = ld_valid && (count != '0);
    assign push      = ld_issue && (!ld_full || ld_valid);
    assign overflow  = ld_issue && ld_full && !ld_valid;
    assign underflow = ld_valid && (count == '0);
    assign pop_sel   = fifo[head];
    assign pop_wr    = pop && (pop_sel != '0);
    assign wb_act    = wb_we && (wb_sel != '0);

    // NOTE: the destination FIFO slots carry no reset; count gates every use of them.
    always_ff @(posedge clk) begin
        if (push)
            fifo[tail] <= ld_sel;
    end

    // NOTE: all sequential state uses non-blocking assignments so every block samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            ld_err <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (overflow)
                ld_err[0] <= 1'b1;
            if (underflow)
                ld_err[1] <= 1'b1;
        end
    end

    // Architectural state is cleared on reset; entry 0 is never written so it stays a constant zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                pend[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (wb_act && (wb_sel == RW'(r)))
                    regs[r] <= wb_data;
                else if (pop_wr && (pop_sel == RW'(r)))
                    regs[r] <= ld_data;
                case ({push && (ld_sel == RW'(r)), pop && (pop_sel == RW'(r))})
                    2'b10:   pend[r] <= pend[r] + 1'b1;
                    2'b01:   pend[r] <= pend[r] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_port
        logic [RW-1:0] sel;
        logic          wb_hit, ld_hit, pend_hit;

        assign sel      = rd_sel[i*RW +: RW];
        assign wb_hit   = wb_act && (wb_sel == sel);
        assign ld_hit   = pop_wr && (pop_sel == sel);
        assign pend_hit = (sel != '0) && (pend[sel] != '0);

`ifdef REGFILE_BYPASS_EN
        assign rd_data[i*XLEN +: XLEN] = (sel == '0) ? '0      :
                                         wb_hit      ? wb_data :
                                         ld_hit      ? ld_data : regs[sel];
        // Only the last outstanding load to this register, returning now, clears the dependency.
        assign port_stall[i] = pend_hit && !(ld_hit && (pend[sel] == CW'(1)));
`else
        assign rd_data[i*XLEN +: XLEN] = (sel == '0) ? '0 : regs[sel];
        assign port_stall[i] = pend_hit || wb_hit || ld_hit;
`endif
    end

    assign hazard_stall = |port_stall;

endmodule

// File: tb/tb_pipe_regfile_sb.sv
// Directed self-checking bench for pipe_regfile_sb; expected values are hand-computed per vector.
// Bypass-dependent expectations follow REGFILE_BYPASS_EN.
module tb_pipe_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int RW   = 5;
    localparam int CW   = 3;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk;
    logic                reset;
    logic [NRD*RW-1:0]   rd_sel;
    logic [NRD*XLEN-1:0] rd_data;
    logic                wb_we;
    logic [RW-1:0]       wb_sel;
    logic [XLEN-1:0]     wb_data;
    logic                ld_issue;
    logic [RW-1:0]       ld_sel;
    logic                ld_valid;
    logic [XLEN-1:0]     ld_data;
    logic                hazard_stall;
    logic                ld_full;
    logic [CW-1:0]       ld_count;
    logic [1:0]          ld_err;

    int vectors     = 0;
    int miscompares = 0;

    pipe_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .LD_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_sel       (rd_sel),
        .rd_data      (rd_data),
        .wb_we        (wb_we),
        .wb_sel       (wb_sel),
        .wb_data      (wb_data),
        .ld_issue     (ld_issue),
        .ld_sel       (ld_sel),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .hazard_stall (hazard_stall),
        .ld_full      (ld_full),
        .ld_count     (ld_count),
        .ld_err       (ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_we    = 1'b0;
        wb_sel   = '0;
        wb_data  = '0;
        ld_issue = 1'b0;
        ld_sel   = '0;
        ld_valid = 1'b0;
        ld_data  = '0;
    endtask

    task automatic read2(input int p0, input int p1);
        rd_sel = {RW'(p1), RW'(p0)};
    endtask

    task automatic issue(input int sel);
        ld_issue = 1'b1;
        ld_sel   = RW'(sel);
        tick();
        ld_issue = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            fill_sel [4];
        int            ret_sel  [4];
        logic [31:0]   ret_dat  [4];

        fill_sel = '{3, 3, 4, 9};
        ret_sel  = '{3, 4, 9, 12};
        ret_dat  = '{32'hA3, 32'hA4, 32'hA9, 32'hAC};

        reset = 1'b1;
        idle();
        read2(0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_count", ld_count, 0);
        check("rst_full", ld_full, 0);
        check("rst_err", ld_err, 0);
        check("rst_stall", hazard_stall, 0);
        for (int r = 0; r < NREG; r++) begin
            read2(r, NREG - 1 - r);
            #1;
            check("rst_rd", rd_data, 0);
        end

        // x0 write must be discarded
        wb_we = 1'b1; wb_sel = 5'd0; wb_data = 32'hDEAD;
        read2(0, 0);
        tick();
        idle();
        #1;
        check("x0_rd", rd_data[31:0], 0);

        // ALU write bypass to x5
        wb_we = 1'b1; wb_sel = 5'd5; wb_data = 32'h1234;
        read2(5, 0);
        #1;
        check("byp_rd", rd_data[31:0], BYP ? 64'h1234 : 64'h0);
        check("byp_stall", hazard_stall, BYP ? 0 : 1);
        tick();
        idle();
        #1;
        check("x5_stored", rd_data[31:0], 32'h1234);
        check("x5_stall", hazard_stall, 0);

        // load-use on x7
        read2(7, 0);
        issue(7);
        #1;
        check("lu_stall", hazard_stall, 1);
        check("lu_count", ld_count, 1);
        tick();
        tick();
        check("lu_stall3", hazard_stall, 1);
        ld_valid = 1'b1; ld_data = 32'hCAFE;
        #1;
        check("lu_ret_stall", hazard_stall, BYP ? 0 : 1);
        check("lu_ret_rd", rd_data[31:0], BYP ? 64'hCAFE : 64'h0);
        tick();
        idle();
        #1;
        check("x7_stored", rd_data[31:0], 32'hCAFE);
        check("x7_stall", hazard_stall, 0);
        check("lu_count0", ld_count, 0);

        // fill the FIFO
        for (int i = 0; i < 4; i++)
            issue(fill_sel[i]);
        #1;
        check("full_flag", ld_full, 1);
        check("full_count", ld_count, 4);
        issue(12);
        #1;
        check("ovf_err", ld_err, 2'b01);
        check("ovf_count", ld_count, 4);

        // issue while full with a return: x3 pops (counter 2 -> 1), x12 pushes
        ld_issue = 1'b1; ld_sel = 5'd12; ld_valid = 1'b1; ld_data = 32'h33;
        read2(3, 0);
        #1;
        check("fr_stall", hazard_stall, 1);
        check("fr_rd", rd_data[31:0], BYP ? 64'h33 : 64'h0);
        tick();
        idle();
        #1;
        check("fr_count", ld_count, 4);
        check("fr_full", ld_full, 1);
        check("fr_err", ld_err, 2'b01);
        check("x3_still_pend", hazard_stall, 1);
        check("x3_first", rd_data[31:0], 32'h33);

        // in-order returns: x3, x4, x9, x12
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_data = ret_dat[i];
            tick();
            idle();
            read2(ret_sel[i], (i < 3) ? ret_sel[i+1] : 0);
            #1;
            check("ret_rd", rd_data[31:0], {32'h0, ret_dat[i]});
            check("ret_next", rd_data[63:32], 0);
            check("ret_count", ld_count, 64'(3 - i));
        end
        check("ret_stall", hazard_stall, 0);

        // x0 destination keeps order and writes nothing
        issue(0);
        issue(6);
        read2(6, 0);
        #1;
        check("z_stall", hazard_stall, 1);
        check("z_count", ld_count, 2);
        ld_valid = 1'b1; ld_data = 32'hEE;
        tick();
        idle();
        #1;
        check("z_x6", rd_data[31:0], 0);
        check("z_x0", rd_data[63:32], 0);
        check("z_stall2", hazard_stall, 1);
        check("z_count1", ld_count, 1);
        ld_valid = 1'b1; ld_data = 32'hF6;
        tick();
        idle();
        #1;
        check("z_x6_ret", rd_data[31:0], 32'hF6);
        check("z_stall0", hazard_stall, 0);

        // WAW: ALU write wins over load return to x2
        issue(2);
        ld_valid = 1'b1; ld_data = 32'h99;
        wb_we = 1'b1; wb_sel = 5'd2; wb_data = 32'h55;
        read2(2, 0);
        #1;
        check("waw_rd", rd_data[31:0], BYP ? 64'h55 : 64'h0);
        check("waw_stall", hazard_stall, BYP ? 0 : 1);
        tick();
        idle();
        #1;
        check("waw_x2", rd_data[31:0], 32'h55);
        check("waw_stall0", hazard_stall, 0);

        // return with nothing outstanding
        ld_valid = 1'b1; ld_data = 32'h77;
        read2(2, 12);
        tick();
        idle();
        #1;
        check("unf_err", ld_err, 2'b11);
        check("unf_count", ld_count, 0);
        check("unf_regs", rd_data, {32'hAC, 32'h55});

        // asynchronous reset with two loads outstanding
        issue(10);
        issue(11);
        read2(10, 11);
        #1;
        check("ar_pre_count", ld_count, 2);
        check("ar_pre_stall", hazard_stall, 1);
        reset = 1'b1;
        #1;
        check("ar_count", ld_count, 0);
        check("ar_stall", hazard_stall, 0);
        check("ar_err", ld_err, 0);
        check("ar_full", ld_full, 0);
        read2(5, 7);
        #1;
        check("ar_regs", rd_data, 0);
        tick();
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
